// File: rtl/bpu_dyn_if.sv
// bpu_dyn_if: fetch-side predictor bus (lookup, prediction, resolved-branch update)
interface bpu_dyn_if #(
    parameter int IDX_BITS = 8
);
    logic [63:0]         pc;
    logic [31:0]         ir;
    logic                jal_taken;
    logic [63:0]         jal_addr;
    logic                pr_taken;
    logic [12:0]         pr_offs;
    logic [IDX_BITS-1:0] pr_idx;
    logic                ready;
    logic                upd_valid;
    logic [IDX_BITS-1:0] upd_idx;
    logic                upd_taken;

    modport master (
        output pc, ir, upd_valid, upd_idx, upd_taken,
        input  jal_taken, jal_addr, pr_taken, pr_offs, pr_idx, ready
    );

    modport slave (
        input  pc, ir, upd_valid, upd_idx, upd_taken,
        output jal_taken, jal_addr, pr_taken, pr_offs, pr_idx, ready
    );
endinterface

// File: rtl/bpu_dyn.sv
// bpu_dyn: JAL/C.J target generation plus static or bimodal/gshare branch direction prediction
module bpu_dyn #(
    parameter int MODE     = 3,
    parameter int IDX_BITS = 8,
    parameter int GHR_BITS = 0
) (
    input logic      clk,
    input logic      rst,
    bpu_dyn_if.slave bus
);
    typedef enum logic {INIT, RUN} state_t;

    state_t              state, state_nx;
    logic [IDX_BITS-1:0] ptr, ptr_nx, hist;
    logic                br32, brc, jal32, cj, dyn_taken;
    logic [20:0]         j_imm;
    logic [11:0]         cj_imm;
    logic [8:0]          cb_imm;
    logic [12:0]         offs;

    always_comb begin
        br32          = bus.ir[6:0] == 7'b1100011;
        brc           = bus.ir[1:0] == 2'b01 && bus.ir[15:14] == 2'b11;
        jal32         = bus.ir[6:0] == 7'b1101111;
        cj            = bus.ir[1:0] == 2'b01 && bus.ir[15:13] == 3'b101;
        j_imm         = {bus.ir[31], bus.ir[19:12], bus.ir[20], bus.ir[30:21], 1'b0};
        cj_imm        = {bus.ir[12], bus.ir[8], bus.ir[10:9], bus.ir[6], bus.ir[7],
                         bus.ir[2], bus.ir[11], bus.ir[5:3], 1'b0};
        cb_imm        = {bus.ir[12], bus.ir[6:5], bus.ir[2], bus.ir[11:10], bus.ir[4:3], 1'b0};
        offs          = br32 ? {bus.ir[31], bus.ir[7], bus.ir[30:25], bus.ir[11:8], 1'b0}
                             : {{4{cb_imm[8]}}, cb_imm};
        bus.jal_taken = jal32 | cj;
        bus.jal_addr  = bus.pc + (jal32 ? {{43{j_imm[20]}}, j_imm} : {{52{cj_imm[11]}}, cj_imm});
        bus.pr_offs   = offs;
        bus.pr_idx    = bus.pc[IDX_BITS:1] ^ hist;
        bus.pr_taken  = (br32 | brc) & (MODE == 0 ? 1'b1 :
                                        MODE == 1 ? 1'b0 :
                                        MODE == 2 ? offs[12] : dyn_taken);
    end

    assign bus.ready = state == RUN;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    // Static modes have no table to sweep, so INIT lasts a single cycle.
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        if (state == INIT) begin
            ptr_nx   = ptr + IDX_BITS'(1);
            state_nx = (MODE != 3 || &ptr) ? RUN : INIT;
        end
    end

    generate
        if (MODE == 3) begin : g_dyn
            logic [1:0] cnt [2**IDX_BITS];
            logic [1:0] cur;
            logic       upd_en;
            assign upd_en = bus.upd_valid & bus.ready;
            assign cur    = cnt[bus.upd_idx];
            // No async reset on the table: INIT rewrites every entry after each reset.
            always_ff @(posedge clk) begin
                if (state == INIT)
                    cnt[ptr] <= 2'b01;
                else if (upd_en)
                    cnt[bus.upd_idx] <= bus.upd_taken ? (&cur ? cur : cur + 2'b01)
                                                      : (~|cur ? cur : cur - 2'b01);
            end
            assign dyn_taken = bus.ready & cnt[bus.pr_idx][1];
            if (GHR_BITS > 0) begin : g_ghr
                logic [GHR_BITS-1:0] ghr;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst)
                        ghr <= '0;
                    else if (upd_en)
                        ghr <= GHR_BITS'({ghr, bus.upd_taken});
                end
                assign hist = IDX_BITS'(ghr);
            end else begin : g_bim
                assign hist = '0;
            end
        end else begin : g_static
            assign dyn_taken = 1'b0;
            assign hist      = '0;
        end
    endgenerate
endmodule

// File: tb/tb_bpu_dyn.sv
// tb_bpu_dyn: scoreboard bench for bimodal, gshare and backward-taken predictor instances
module tb_bpu_dyn;
    localparam logic [31:0] BEQ_M8  = 32'hFE208CE3;
    localparam logic [31:0] BNE_P16 = 32'h00209863;
    localparam logic [31:0] BNE_M16 = 32'hFE2098E3;
    localparam logic [31:0] CBNEZ_M4 = 32'h0000FC75;
    localparam logic [31:0] JAL_800 = 32'h0010006F;
    localparam logic [31:0] CJ_M2   = 32'h0000BFFD;
    localparam logic [31:0] ADDI    = 32'h00000013;

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] val;
    } exp_t;

    logic  clk = 0;
    logic  rst;
    exp_t  sb[$];
    exp_t  e;
    int    n_vec = 0;
    int    n_err = 0;

    bpu_dyn_if #(.IDX_BITS(8)) a ();
    bpu_dyn_if #(.IDX_BITS(8)) g ();
    bpu_dyn_if #(.IDX_BITS(8)) s ();

    bpu_dyn #(.MODE(3), .IDX_BITS(8), .GHR_BITS(0)) dut_a (.clk(clk), .rst(rst), .bus(a));
    bpu_dyn #(.MODE(3), .IDX_BITS(8), .GHR_BITS(4)) dut_g (.clk(clk), .rst(rst), .bus(g));
    bpu_dyn #(.MODE(2), .IDX_BITS(8), .GHR_BITS(0)) dut_s (.clk(clk), .rst(rst), .bus(s));

    always #5 clk = ~clk;

    function automatic logic [63:0] act(int sel);
        case (sel)
            0:  return {63'd0, a.jal_taken};
            1:  return a.jal_addr;
            2:  return {63'd0, a.pr_taken};
            3:  return {51'd0, a.pr_offs};
            4:  return {56'd0, a.pr_idx};
            5:  return {63'd0, a.ready};
            12: return {63'd0, g.pr_taken};
            14: return {56'd0, g.pr_idx};
            15: return {63'd0, g.ready};
            22: return {63'd0, s.pr_taken};
            23: return {51'd0, s.pr_offs};
            25: return {63'd0, s.ready};
            default: return 64'hDEAD_BEEF_DEAD_BEEF;
        endcase
    endfunction

    task automatic put(string n, int sel, logic [63:0] v);
        sb.push_back('{n, sel, v});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++;
            if (act(e.sel) !== e.val) begin
                n_err++;
                $display("FAIL %s: got %h want %h", e.name, act(e.sel), e.val);
            end
        end
    end

    task automatic sweep(bit first);
        for (int k = 0; k <= 256; k++) begin
            if (k > 0) tick();
            if (first && k == 0) begin
                a.pc = 64'h2000; a.ir = JAL_800;
                put("init_jal_taken", 0, 1); put("init_jal_addr", 1, 64'h2800);
                put("init_ready_a", 5, 0); put("init_ready_s0", 25, 0);
            end
            if (first && k == 1) begin
                a.pc = 64'h10; a.ir = CJ_M2;
                put("init_cj_taken", 0, 1); put("init_cj_addr", 1, 64'hE);
                put("ready_s_edge1", 25, 1);
            end
            if (first && k == 2) begin
                a.ir = ADDI;
                put("init_addi_nojal", 0, 0);
            end
            if (!first && k == 100) put("init_pred_gated", 2, 0);
            if (k == 255) begin
                a.upd_valid = 0; g.upd_valid = 0;
                put("init_ready_a_255", 5, 0); put("init_ready_g_255", 15, 0);
            end
            if (k == 256) begin
                put("run_ready_a_256", 5, 1); put("run_ready_g_256", 15, 1);
            end
        end
    endtask

    task automatic scan();
        for (int i = 0; i < 256; i++) begin
            tick();
            a.pc = 64'(i * 2); a.ir = BEQ_M8;
            put("scan_wnt", 2, 0);
            if (i == 8'hA5) put("scan_idx", 4, 64'hA5);
        end
    endtask

    initial begin
        string ups, exps;
        a.pc = 0; a.ir = ADDI; a.upd_valid = 0; a.upd_idx = 0; a.upd_taken = 0;
        g.pc = 0; g.ir = ADDI; g.upd_valid = 0; g.upd_idx = 0; g.upd_taken = 0;
        s.pc = 0; s.ir = ADDI; s.upd_valid = 0; s.upd_idx = 0; s.upd_taken = 0;
        rst = 1;
        tick();
        put("rst_ready_a", 5, 0); put("rst_ready_g", 15, 0); put("rst_ready_s", 25, 0);
        tick();
        tick();
        rst = 0;
        a.upd_valid = 1; a.upd_idx = 0; a.upd_taken = 1;
        g.upd_valid = 1; g.upd_taken = 1;
        sweep(1);
        tick();
        g.pc = 64'h40; g.ir = BEQ_M8;
        put("ghr_zero_idx", 14, 64'h20);
        scan();
        // counter walk on entry 0: prediction reflects the value before each update
        ups  = "TTTNNNNTT-";
        exps = "0111100001";
        a.pc = 64'h1000;
        for (int i = 0; i < 10; i++) begin
            tick();
            a.upd_valid = ups[i] != "-"; a.upd_idx = 0; a.upd_taken = ups[i] == "T";
            put("cnt_seq", 2, {63'd0, exps[i] == "1"});
            if (i == 0) begin
                put("beq_offs", 3, 64'h1FF8); put("beq_idx", 4, 0);
            end
        end
        tick();
        a.upd_valid = 1; a.upd_idx = 8'hF0; a.upd_taken = 1;
        tick();
        tick();
        a.upd_valid = 0; a.pc = 64'h1E0;
        put("trained_f0", 2, 1);
        ups = "TTNT-";
        for (int i = 0; i < 5; i++) begin
            tick();
            g.upd_valid = ups[i] != "-"; g.upd_taken = ups[i] == "T";
            case (i)
                0: put("ghr_idx0", 14, 64'h20);
                1: put("ghr_idx1", 14, 64'h21);
                2: put("ghr_idx2", 14, 64'h23);
                3: put("ghr_idx3", 14, 64'h26);
                default: put("ghr_1101", 14, 64'h2D);
            endcase
        end
        tick();
        rst = 1;
        put("rst_run_ready_a", 5, 0); put("rst_run_ready_g", 15, 0);
        put("rst_run_ready_s", 25, 0); put("rst_ghr_clr", 14, 64'h20);
        put("rst_pred_a", 2, 0);
        tick();
        tick();
        rst = 0;
        a.upd_valid = 1; a.upd_idx = 8'h10; a.upd_taken = 1;
        g.upd_valid = 1; g.upd_taken = 1;
        sweep(0);
        put("resweep_ghr", 14, 64'h20);
        scan();
        tick();
        a.pc = 64'h0A; a.upd_valid = 1; a.upd_idx = 5; a.upd_taken = 1;
        put("wnt_pre", 2, 0);
        tick();
        a.upd_valid = 0;
        put("wnt_one_taken", 2, 1);
        tick();
        a.ir = ADDI;
        put("nonbranch_a", 2, 0);
        s.pc = 64'h3000; s.ir = BNE_P16;
        put("s_bne_p16", 22, 0); put("s_offs_p16", 23, 64'h0010); put("s_ready", 25, 1);
        tick();
        s.ir = BNE_M16;
        put("s_bne_m16", 22, 1); put("s_offs_m16", 23, 64'h1FF0);
        tick();
        s.ir = CBNEZ_M4;
        put("s_cbnez", 22, 1); put("s_offs_cb", 23, 64'h1FFC);
        tick();
        s.ir = ADDI;
        put("s_addi", 22, 0);
        tick();
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
